// File: rtl/exu_branchslv_pkg.sv
// -----------------------------------------------------------------------------
// exu_branchslv_pkg
// Shared definitions for the execute-side branch resolution slave:
//   - FSM state encoding (IDLE / FLUSH_PEND)
//   - sequential-increment constants for compressed and normal instructions
//   - helper returning the fall-through increment for an instruction size
// Optional feature macro used by the top: BJP_STAT_EN.
// -----------------------------------------------------------------------------
package exu_branchslv_pkg;

   typedef enum logic [0:0] {
      BSLV_IDLE = 1'b0,
      BSLV_PEND = 1'b1
   } bslv_state_e;

   localparam logic [2:0] BSLV_INC_RVC  = 3'd2;
   localparam logic [2:0] BSLV_INC_RV32 = 3'd4;

   // Fall-through distance of an instruction: 4 bytes normal, 2 compressed.
   function automatic logic [2:0] bslv_seq_inc(input logic rv32);
      logic [2:0] inc;
      if (rv32) begin
         inc = BSLV_INC_RV32;
      end else begin
         inc = BSLV_INC_RVC;
      end
      return inc;
   endfunction

endpackage

// File: rtl/exu_branchslv_if.sv
// -----------------------------------------------------------------------------
// exu_branchslv_if
// Handshake and redirect bus between the EXU ALU/BJP path, the branch
// resolution slave and the IFU/commit logic.
//   master : environment side (ALU drives the resolved instruction, IFU
//            returns flush_ack)
//   slave  : exu_branchslv (accepts instructions, issues commit and redirect)
// Signals:
//   i_valid/i_ready           instruction handshake
//   i_pc, i_bjp_imm           PC and branch offset (PC_SIZE)
//   i_is_jal/jalr/bxx, i_rv32 instruction type and size
//   i_prdt_taken/i_rslv_taken predicted vs. resolved direction
//   o_cmt_valid/o_cmt_flush   one-cycle commit pulse, mispredict qualifier
//   flush_req/flush_ack       redirect handshake to the IFU
//   flush_pc_add_op1/op2      redirect adder operands
// -----------------------------------------------------------------------------
interface exu_branchslv_if #(
   parameter int unsigned PC_SIZE = 32
);
   logic               i_valid;
   logic               i_ready;
   logic [PC_SIZE-1:0] i_pc;
   logic               i_is_jal;
   logic               i_is_jalr;
   logic               i_is_bxx;
   logic               i_rv32;
   logic [PC_SIZE-1:0] i_bjp_imm;
   logic               i_prdt_taken;
   logic               i_rslv_taken;
   logic               o_cmt_valid;
   logic               o_cmt_flush;
   logic               flush_req;
   logic               flush_ack;
   logic [PC_SIZE-1:0] flush_pc_add_op1;
   logic [PC_SIZE-1:0] flush_pc_add_op2;

   modport slave (
      input  i_valid, i_pc, i_is_jal, i_is_jalr, i_is_bxx, i_rv32,
             i_bjp_imm, i_prdt_taken, i_rslv_taken, flush_ack,
      output i_ready, o_cmt_valid, o_cmt_flush, flush_req,
             flush_pc_add_op1, flush_pc_add_op2
   );

   modport master (
      output i_valid, i_pc, i_is_jal, i_is_jalr, i_is_bxx, i_rv32,
             i_bjp_imm, i_prdt_taken, i_rslv_taken, flush_ack,
      input  i_ready, o_cmt_valid, o_cmt_flush, flush_req,
             flush_pc_add_op1, flush_pc_add_op2
   );
endinterface

// File: rtl/exu_bslv_stat.sv
// -----------------------------------------------------------------------------
// exu_bslv_stat
// Branch statistics counters, instantiated only when BJP_STAT_EN is defined.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   inc_bjp_i    an accepted instruction carried a branch/jump type bit
//   inc_mis_i    an accepted instruction was a mispredicted branch
//   bjp_cnt_o    branch/jump count (CNT_W, wraps)
//   mis_cnt_o    mispredict count (CNT_W, wraps)
// -----------------------------------------------------------------------------
module exu_bslv_stat #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_bjp_i,
   input  logic             inc_mis_i,
   output logic [CNT_W-1:0] bjp_cnt_o,
   output logic [CNT_W-1:0] mis_cnt_o
);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] bjp_cnt_q, bjp_cnt_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

   // Next-state for both counters; natural overflow gives the wrap.
   always_comb begin
      bjp_cnt_d = bjp_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (inc_bjp_i) begin
         bjp_cnt_d = bjp_cnt_q + CNT_ONE;
      end else begin
         bjp_cnt_d = bjp_cnt_q;
      end
      if (inc_mis_i) begin
         mis_cnt_d = mis_cnt_q + CNT_ONE;
      end else begin
         mis_cnt_d = mis_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bjp_cnt_q <= {CNT_W{1'b0}};
         mis_cnt_q <= {CNT_W{1'b0}};
      end else begin
         bjp_cnt_q <= bjp_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign bjp_cnt_o = bjp_cnt_q;
   assign mis_cnt_o = mis_cnt_q;

endmodule

// File: rtl/exu_branchslv.sv
// -----------------------------------------------------------------------------
// exu_branchslv
// Execute-side branch resolution slave. Accepts one resolved branch/jump per
// handshake, compares the IFU prediction with the real outcome and, on a
// conditional-branch mispredict, holds a redirect request (op1 + op2 computed
// by the IFU) until the IFU acknowledges it.
// Ports:
//   clk            single clock
//   rst            asynchronous active-low reset
//   bus            exu_branchslv_if.slave (handshake, commit, redirect)
//   stat_bjp_cnt   [BJP_STAT_EN only] accepted branch/jump count
//   stat_mis_cnt   [BJP_STAT_EN only] mispredict count
// Optional feature macro: BJP_STAT_EN (adds the statistics counters).
// -----------------------------------------------------------------------------
module exu_branchslv
   import exu_branchslv_pkg::*;
#(
   parameter int unsigned PC_SIZE = 32,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   exu_branchslv_if.slave       bus
`ifdef BJP_STAT_EN
   ,
   output logic [CNT_W-1:0]     stat_bjp_cnt,
   output logic [CNT_W-1:0]     stat_mis_cnt
`endif
);

   bslv_state_e        state_q, state_d;
   logic               cmt_valid_q, cmt_valid_d;
   logic               cmt_flush_q, cmt_flush_d;
   logic [PC_SIZE-1:0] op1_q, op1_d;
   logic [PC_SIZE-1:0] op2_q, op2_d;

   logic               accept_s;
   logic               sel_jal_s;
   logic               sel_jalr_s;
   logic               sel_bxx_s;
   logic               any_type_s;
   logic               mis_s;

   assign accept_s = bus.i_valid & (state_q == BSLV_IDLE);

   // Type priority jal > jalr > bxx; only a bxx that wins can mispredict,
   // so a jal/jalr with a stray bxx bit never redirects.
   assign sel_jal_s  = bus.i_is_jal;
   assign sel_jalr_s = ~bus.i_is_jal & bus.i_is_jalr;
   assign sel_bxx_s  = ~bus.i_is_jal & ~bus.i_is_jalr & bus.i_is_bxx;
   assign any_type_s = sel_jal_s | sel_jalr_s | sel_bxx_s;
   assign mis_s      = sel_bxx_s & (bus.i_prdt_taken != bus.i_rslv_taken);

   // FSM next state, commit pulse and redirect operand capture.
   always_comb begin
      state_d     = state_q;
      cmt_valid_d = accept_s;
      cmt_flush_d = accept_s & mis_s;
      op1_d       = op1_q;
      op2_d       = op2_q;
      case (state_q)
         BSLV_IDLE: begin
            if (accept_s & mis_s) begin
               state_d = BSLV_PEND;
               op1_d   = bus.i_pc;
               // Predicted taken but fell through: redirect to the next
               // sequential PC; otherwise redirect to the branch target.
               if (bus.i_prdt_taken) begin
                  op2_d = {{(PC_SIZE-3){1'b0}}, bslv_seq_inc(bus.i_rv32)};
               end else begin
                  op2_d = bus.i_bjp_imm;
               end
            end else begin
               state_d = BSLV_IDLE;
            end
         end
         BSLV_PEND: begin
            if (bus.flush_ack) begin
               state_d = BSLV_IDLE;
            end else begin
               state_d = BSLV_PEND;
            end
         end
         default: begin
            state_d = BSLV_IDLE;
         end
      endcase
   end

   // State, commit and operand registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= BSLV_IDLE;
         cmt_valid_q <= 1'b0;
         cmt_flush_q <= 1'b0;
         op1_q       <= {PC_SIZE{1'b0}};
         op2_q       <= {PC_SIZE{1'b0}};
      end else begin
         state_q     <= state_d;
         cmt_valid_q <= cmt_valid_d;
         cmt_flush_q <= cmt_flush_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
      end
   end

   // flush_req is the PEND state bit itself, so reset drops it at once.
   assign bus.i_ready          = (state_q == BSLV_IDLE);
   assign bus.flush_req        = (state_q == BSLV_PEND);
   assign bus.o_cmt_valid      = cmt_valid_q;
   assign bus.o_cmt_flush      = cmt_flush_q;
   assign bus.flush_pc_add_op1 = op1_q;
   assign bus.flush_pc_add_op2 = op2_q;

`ifdef BJP_STAT_EN
   exu_bslv_stat #(
      .CNT_W (CNT_W)
   ) u_stat (
      .clk       (clk),
      .rst       (rst),
      .inc_bjp_i (accept_s & any_type_s),
      .inc_mis_i (accept_s & mis_s),
      .bjp_cnt_o (stat_bjp_cnt),
      .mis_cnt_o (stat_mis_cnt)
   );
`else
   logic unused_s;
   assign unused_s = any_type_s;
`endif

endmodule

// File: doc/exu_branchslv.md
Name: exu_branchslv

Overview:
- Execute-side branch resolution slave: the far end of the IFU lite branch-prediction interface.
- Accepts one resolved branch/jump per handshake from the ALU/BJP path and compares the IFU's `prdt_taken` with the real outcome.
- On a mismatch it issues a redirect (flush) request back to the IFU. The IFU computes the new PC as `flush_pc_add_op1 + flush_pc_add_op2`, using the same op1/op2 adder convention as prediction.
- Sits between the EXU ALU and the IFU/commit logic.

Parameters:
- `PC_SIZE`, 32, PC width; all PC and operand buses use it.
- `CNT_W`, 32, statistics counter width (used only with `BJP_STAT_EN`).

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-low reset
- `i_valid`  in  1  resolved instruction presented
- `i_ready`  out  1  block can accept
- `i_pc`  in  PC_SIZE  PC of the instruction
- `i_is_jal`  in  1  instruction is JAL
- `i_is_jalr`  in  1  instruction is JALR
- `i_is_bxx`  in  1  instruction is a conditional branch
- `i_rv32`  in  1  1 = 4-byte instruction, 0 = 2-byte (compressed)
- `i_bjp_imm`  in  PC_SIZE  branch offset (sign-extended, truncated to PC_SIZE)
- `i_prdt_taken`  in  1  IFU prediction carried with the instruction
- `i_rslv_taken`  in  1  ALU-resolved condition
- `o_cmt_valid`  out  1  registered one-cycle commit pulse
- `o_cmt_flush`  out  1  qualifies `o_cmt_valid`: mispredict
- `flush_req`  out  1  redirect request to IFU
- `flush_ack`  in  1  IFU accepts redirect
- `flush_pc_add_op1`  out  PC_SIZE  redirect base
- `flush_pc_add_op2`  out  PC_SIZE  redirect offset

Behaviour:
- Reset (`rst` low, asynchronous): state=IDLE; `flush_req`=0; `o_cmt_valid`=0; `o_cmt_flush`=0; op1/op2=0.
- Reset mid-flush: the pending request is dropped immediately; no ack is expected afterwards.
- States: IDLE and FLUSH_PEND.
- `i_ready` = (state==IDLE). Accept occurs on `i_valid & i_ready`.
- Type priority when more than one type bit is set: jal > jalr > bxx.
- No type bit set: accept, commit with no flush.
- Mispredict condition: `mis = i_is_bxx & (i_prdt_taken != i_rslv_taken)`.
  - JAL and JALR never mispredict: the IFU always predicts them taken with an exact target.
- Redirect operands (captured at accept):
  - Predicted taken, resolved not taken: op1=`i_pc`, op2 = `i_rv32` ? 4 : 2.
  - Predicted not taken, resolved taken: op1=`i_pc`, op2=`i_bjp_imm`.
  - Addition is done by the IFU modulo 2^PC_SIZE; wrap-around is legal.
- Commit pulse: every accept produces `o_cmt_valid`=1 for exactly one cycle, in the cycle after the accept, with `o_cmt_flush`=`mis`.
- IDLE transitions:
  - Accept with `mis`=1 → FLUSH_PEND, and `flush_req`=1 from the next cycle.
  - Otherwise stay in IDLE; back-to-back accepts every cycle are allowed.
- FLUSH_PEND:
  - `flush_req`, op1 and op2 are held stable until `flush_ack` is sampled high.
  - On ack: → IDLE; `flush_req`=0 and `i_ready`=1 in the next cycle.
  - `flush_ack` is ignored when `flush_req`=0.
- Ack in the first FLUSH_PEND cycle is legal: minimum turnaround is 2 cycles from accept to the next accept.
- Latency: accept→`flush_req` = 1 cycle; accept→`o_cmt_valid` = 1 cycle.

Optional Feature:
- Macro: `BJP_STAT_EN`.
- Defined:
  - Adds outputs `stat_bjp_cnt` and `stat_mis_cnt` (CNT_W each).
  - `stat_bjp_cnt` increments on every accept with any type bit set.
  - `stat_mis_cnt` increments on every accept with `mis`.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: no counters and no stat ports; the behaviour of all other ports is identical.

Decomposition:
- Shared `defines.v` provides:
  - `PC_SIZE`
  - FSM state encodings: `BSLV_IDLE`=1'b0, `BSLV_PEND`=1'b1
  - The compressed/normal increment constants (2, 4)
- All flops are built from the existing `sirv_gnrl_dfflr`-style general DFF cells.
- One natural sub-module: `exu_bslv_stat`, holding the two counters and instantiated only under `BJP_STAT_EN`.

Test Plan:
- Correct bxx prediction: `i_pc`=0x8000_0000, prdt=1, rslv=1 → `o_cmt_valid`=1, `o_cmt_flush`=0, `flush_req` stays 0; a second accept is taken in the next cycle.
- Predicted taken, not taken: `i_pc`=0x8000_0010, `i_rv32`=1 → `flush_req`=1 one cycle later with op1=0x8000_0010, op2=4. With `i_rv32`=0 → op2=2.
- Predicted not taken, taken: `i_pc`=0x8000_0100, imm=0xFFFF_FFF0 → op1=0x8000_0100, op2=0xFFFF_FFF0. `flush_ack` held low for 3 cycles → `flush_req`, op1 and op2 stable and `i_ready`=0 throughout; ack → `i_ready`=1 the next cycle.
- JAL/JALR: `i_is_jal`=1, prdt=0, rslv=1 → no flush; `o_cmt_flush`=0.
- Reset: pull `rst` low while in FLUSH_PEND → `flush_req`=0 immediately; after release, state is IDLE and `i_ready`=1.
- `BJP_STAT_EN`: 5 branches including 2 mispredicts → `stat_bjp_cnt`=5, `stat_mis_cnt`=2. With CNT_W=4 and 16 mispredicts → `stat_mis_cnt` wraps to 0.
